rom_fetch_buffer: RTL and testbench

Cartridge-ROM fetch buffer between the coprocessor cartridge mapper and the SDRAM controller port. It captures each mapped ROM read strobe (`ROM_ADDR`, `ROM_CE_N`, `ROM_OE_N`) and runs a req/ack read against word-wide memory. It presents the result on `ROM_Q` and keeps a one-word hit buffer so repeated reads of the same word skip memory. Refresh deferral, one-deep request queueing and a timeout watchdog prevent a stalled memory port from hanging the bus.

---
 rtl/rom_fetch_buffer_if.sv | 26 ++
 rtl/rom_fetch_buffer.sv | 179 +++++++++++++++++
 tb/tb_rom_fetch_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_buffer_if.sv
// Mapper ROM strobe bus plus SDRAM read port seen by the ROM fetch buffer.
interface rom_fetch_buffer_if;
   logic [23:0] ROM_ADDR;
   logic        ROM_CE_N;
   logic        ROM_OE_N;
   logic        ROM_WORD;
   logic        INVALIDATE;
   logic        REFRESH;
   logic [15:0] ROM_Q;
   logic [22:0] MEM_ADDR;
   logic        MEM_REQ;
   logic        MEM_ACK;
   logic [15:0] MEM_DQ;
   logic        BUSY;
   logic        ERR;

   modport master (
      output ROM_ADDR, ROM_CE_N, ROM_OE_N, ROM_WORD, INVALIDATE, REFRESH, MEM_ACK, MEM_DQ,
      input  ROM_Q, MEM_ADDR, MEM_REQ, BUSY, ERR
   );

   modport slave (
      input  ROM_ADDR, ROM_CE_N, ROM_OE_N, ROM_WORD, INVALIDATE, REFRESH, MEM_ACK, MEM_DQ,
      output ROM_Q, MEM_ADDR, MEM_REQ, BUSY, ERR
   );
endinterface

// File: rtl/rom_fetch_buffer.sv
// Cartridge-ROM fetch buffer: one-word hit buffer, refresh deferral, one-deep
// newest-wins request queue and a req/ack timeout watchdog toward SDRAM.
module rom_fetch_buffer #(
   parameter int unsigned TIMEOUT  = 24,
   parameter bit          CACHE_EN = 1'b1
) (
   input  logic               WCLK,
   input  logic               RST_N,
   rom_fetch_buffer_if.slave  bus
);
   localparam int unsigned AW = 24;
   localparam int unsigned WW = 23;
   localparam int unsigned DW = 16;
   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DEFER = 2'd1;
   localparam logic [1:0] S_REQ   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] rom_q_q, rom_q_d;
   logic [WW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_req_q, mem_req_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          valid_q, valid_d;
   logic [WW-1:0] tag_q, tag_d;
   logic [DW-1:0] data_q, data_d;
   logic          cur_hi_q, cur_hi_d;
   logic          cur_word_q, cur_word_d;
   logic          pend_v_q, pend_v_d;
   logic [AW-1:0] pend_addr_q, pend_addr_d;
   logic          pend_word_q, pend_word_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          strobe, req_v, req_word, req_hit, do_start, done;
   logic [AW-1:0] req_addr;

   // Byte reads put the addressed byte in [7:0] and the other byte in [15:8].
   function automatic logic [DW-1:0] fmt(input logic [DW-1:0] w, input logic hi, input logic word);
      if (word) return w;
      return hi ? {w[7:0], w[15:8]} : w;
   endfunction

   // A fresh strobe always takes priority over (and replaces) a queued one.
   always_comb begin
      strobe   = !bus.ROM_OE_N && !bus.ROM_CE_N;
      req_v    = strobe || pend_v_q;
      req_addr = strobe ? bus.ROM_ADDR : pend_addr_q;
      req_word = strobe ? bus.ROM_WORD : pend_word_q;
      req_hit  = CACHE_EN && valid_q && (tag_q == req_addr[AW-1:1]) && !bus.INVALIDATE;
   end

   always_comb begin
      state_d     = state_q;
      rom_q_d     = rom_q_q;
      mem_addr_d  = mem_addr_q;
      mem_req_d   = mem_req_q;
      err_d       = err_q;
      valid_d     = valid_q && !bus.INVALIDATE;
      tag_d       = tag_q;
      data_d      = data_q;
      cur_hi_d    = cur_hi_q;
      cur_word_d  = cur_word_q;
      pend_v_d    = pend_v_q;
      pend_addr_d = pend_addr_q;
      pend_word_d = pend_word_q;
      cnt_d       = cnt_q;
      do_start    = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_v) begin
               pend_v_d = 1'b0;
               if (req_hit) rom_q_d = fmt(data_q, req_addr[0], req_word);
               else         do_start = 1'b1;
            end
         end
         S_DEFER: begin
            if (!bus.REFRESH) begin
               state_d   = S_REQ;
               mem_req_d = 1'b1;
               cnt_d     = '0;
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.MEM_ACK) begin
               data_d  = bus.MEM_DQ;
               tag_d   = mem_addr_q;
               valid_d = !bus.INVALIDATE;
               rom_q_d = fmt(bus.MEM_DQ, cur_hi_q, cur_word_q);
               done    = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               rom_q_d = 16'hFFFF;
               err_d   = 1'b1;
               valid_d = 1'b0;
               done    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_q != S_IDLE) && strobe) begin
         pend_v_d    = 1'b1;
         pend_addr_d = bus.ROM_ADDR;
         pend_word_d = bus.ROM_WORD;
      end

      // A queued request that hits the freshly loaded word stays queued and is served from IDLE.
      if (done) begin
         state_d   = S_IDLE;
         mem_req_d = 1'b0;
         if (req_v && !(CACHE_EN && valid_d && (tag_d == req_addr[AW-1:1]) && !bus.INVALIDATE)) begin
            pend_v_d = 1'b0;
            do_start = 1'b1;
         end
      end

      if (do_start) begin
         mem_addr_d = req_addr[AW-1:1];
         cur_hi_d   = req_addr[0];
         cur_word_d = req_word;
         cnt_d      = '0;
         if (bus.REFRESH) begin
            state_d = S_DEFER;
         end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge WCLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         rom_q_q     <= 16'hFFFF;
         mem_addr_q  <= '0;
         mem_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         valid_q     <= 1'b0;
         tag_q       <= '0;
         data_q      <= '0;
         cur_hi_q    <= 1'b0;
         cur_word_q  <= 1'b0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         pend_word_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rom_q_q     <= rom_q_d;
         mem_addr_q  <= mem_addr_d;
         mem_req_q   <= mem_req_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         valid_q     <= valid_d;
         tag_q       <= tag_d;
         data_q      <= data_d;
         cur_hi_q    <= cur_hi_d;
         cur_word_q  <= cur_word_d;
         pend_v_q    <= pend_v_d;
         pend_addr_q <= pend_addr_d;
         pend_word_q <= pend_word_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.ROM_Q    = rom_q_q;
   assign bus.MEM_ADDR = mem_addr_q;
   assign bus.MEM_REQ  = mem_req_q;
   assign bus.BUSY     = busy_q;
   assign bus.ERR      = err_q;
endmodule

// File: tb/tb_rom_fetch_buffer.sv
// Directed bench for rom_fetch_buffer: default instance plus a CACHE_EN=0 instance.
module tb_rom_fetch_buffer;
   logic WCLK = 1'b0;
   logic RST_N;
   int   vecs = 0;
   int   errs = 0;
   bit   saw_0200 = 1'b0;

   rom_fetch_buffer_if bus();
   rom_fetch_buffer_if bus2();

   rom_fetch_buffer u_dut (.WCLK(WCLK), .RST_N(RST_N), .bus(bus));
   rom_fetch_buffer #(.TIMEOUT(24), .CACHE_EN(1'b0)) u_nc (.WCLK(WCLK), .RST_N(RST_N), .bus(bus2));

   always #5 WCLK = ~WCLK;

   // Records whether byte address 0x000200 ever reached the memory port.
   always @(negedge WCLK) if (bus.MEM_REQ && bus.MEM_ADDR == 23'h000100) saw_0200 = 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge WCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [23:0] a, input logic w);
      bus.ROM_ADDR = a; bus.ROM_WORD = w; bus.ROM_CE_N = 1'b0; bus.ROM_OE_N = 1'b0;
      tick();
      bus.ROM_CE_N = 1'b1; bus.ROM_OE_N = 1'b1;
   endtask

   task automatic ack(input logic [15:0] d);
      bus.MEM_DQ = d; bus.MEM_ACK = 1'b1;
      tick();
      bus.MEM_ACK = 1'b0;
   endtask

   task automatic strobe2(input logic [23:0] a, input logic w);
      bus2.ROM_ADDR = a; bus2.ROM_WORD = w; bus2.ROM_CE_N = 1'b0; bus2.ROM_OE_N = 1'b0;
      tick();
      bus2.ROM_CE_N = 1'b1; bus2.ROM_OE_N = 1'b1;
   endtask

   task automatic ack2(input logic [15:0] d);
      bus2.MEM_DQ = d; bus2.MEM_ACK = 1'b1;
      tick();
      bus2.MEM_ACK = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0;
      bus.ROM_ADDR = '0; bus.ROM_CE_N = 1'b1; bus.ROM_OE_N = 1'b1; bus.ROM_WORD = 1'b0;
      bus.INVALIDATE = 1'b0; bus.REFRESH = 1'b0; bus.MEM_ACK = 1'b0; bus.MEM_DQ = '0;
      bus2.ROM_ADDR = '0; bus2.ROM_CE_N = 1'b1; bus2.ROM_OE_N = 1'b1; bus2.ROM_WORD = 1'b0;
      bus2.INVALIDATE = 1'b0; bus2.REFRESH = 1'b0; bus2.MEM_ACK = 1'b0; bus2.MEM_DQ = '0;
      tick(); tick();
      RST_N = 1'b1;

      // Reset values
      check("rst_rom_q", bus.ROM_Q, 32'hFFFF);
      check("rst_mem_req", bus.MEM_REQ, 0);
      check("rst_mem_addr", bus.MEM_ADDR, 0);
      check("rst_busy", bus.BUSY, 0);
      check("rst_err", bus.ERR, 0);

      // Miss on 0x012345 byte, then hits in the same word
      strobe(24'h012345, 1'b0);
      check("miss_req", bus.MEM_REQ, 1);
      check("miss_addr", bus.MEM_ADDR, 32'h0091A2);
      check("miss_busy", bus.BUSY, 1);
      tick(); tick();
      check("miss_q_stable", bus.ROM_Q, 32'hFFFF);
      ack(16'hBEEF);
      check("miss_q", bus.ROM_Q, 32'hEFBE);
      check("miss_req_low", bus.MEM_REQ, 0);
      check("miss_busy_low", bus.BUSY, 0);
      strobe(24'h012344, 1'b0);
      check("hit_lo_req", bus.MEM_REQ, 0);
      check("hit_lo_q", bus.ROM_Q, 32'hBEEF);
      strobe(24'h012345, 1'b1);
      check("hit_word_q", bus.ROM_Q, 32'hBEEF);
      check("hit_word_busy", bus.BUSY, 0);

      // Refresh high five cycles, strobe in the first
      bus.REFRESH = 1'b1;
      strobe(24'h000400, 1'b1);
      check("defer_busy", bus.BUSY, 1);
      tick(); tick(); tick();
      check("defer_req_c4", bus.MEM_REQ, 0);
      tick();
      bus.REFRESH = 1'b0;
      check("defer_req_c5", bus.MEM_REQ, 0);
      tick();
      check("defer_req_c6", bus.MEM_REQ, 1);
      check("defer_addr", bus.MEM_ADDR, 32'h000200);
      bus.REFRESH = 1'b1;
      tick();
      check("refresh_in_req", bus.MEM_REQ, 1);
      ack(16'h1234);
      bus.REFRESH = 1'b0;
      check("defer_q", bus.ROM_Q, 32'h1234);

      // Queue: newest pending strobe wins
      strobe(24'h000100, 1'b1);
      check("q_first_addr", bus.MEM_ADDR, 32'h000080);
      strobe(24'h000200, 1'b1);
      strobe(24'h000300, 1'b1);
      check("q_hold_addr", bus.MEM_ADDR, 32'h000080);
      ack(16'hAAAA);
      check("q_first_q", bus.ROM_Q, 32'hAAAA);
      check("q_next_req", bus.MEM_REQ, 1);
      check("q_next_addr", bus.MEM_ADDR, 32'h000180);
      ack(16'h5555);
      check("q_second_q", bus.ROM_Q, 32'h5555);
      check("q_idle", bus.BUSY, 0);
      check("q_0200_never", saw_0200, 0);

      // Timeout after 24 request cycles
      strobe(24'h000800, 1'b1);
      for (int i = 0; i < 23; i++) tick();
      check("to_req_c23", bus.MEM_REQ, 1);
      check("to_err_pre", bus.ERR, 0);
      tick();
      check("to_req_low", bus.MEM_REQ, 0);
      check("to_q", bus.ROM_Q, 32'hFFFF);
      check("to_err", bus.ERR, 1);
      check("to_busy", bus.BUSY, 0);
      ack(16'h7777);
      check("late_ack_q", bus.ROM_Q, 32'hFFFF);
      check("late_ack_busy", bus.BUSY, 0);
      strobe(24'h000800, 1'b1);
      check("to_restrobe_miss", bus.MEM_REQ, 1);
      ack(16'h0A0B);
      check("to_refetch_q", bus.ROM_Q, 32'h0A0B);
      check("err_sticky", bus.ERR, 1);

      // Invalidate against strobe and against ack
      strobe(24'h000801, 1'b0);
      check("hit_hi_req", bus.MEM_REQ, 0);
      check("hit_hi_q", bus.ROM_Q, 32'h0B0A);
      bus.INVALIDATE = 1'b1;
      strobe(24'h000800, 1'b1);
      bus.INVALIDATE = 1'b0;
      check("inv_strobe_miss", bus.MEM_REQ, 1);
      ack(16'hC0DE);
      check("inv_q", bus.ROM_Q, 32'hC0DE);
      strobe(24'h000900, 1'b1);
      bus.INVALIDATE = 1'b1;
      ack(16'h1111);
      bus.INVALIDATE = 1'b0;
      check("inv_ack_q", bus.ROM_Q, 32'h1111);
      strobe(24'h000900, 1'b1);
      check("inv_ack_miss", bus.MEM_REQ, 1);
      ack(16'h2222);
      check("inv_ack_refetch", bus.ROM_Q, 32'h2222);

      // Reset in the middle of a fetch
      strobe(24'h000A00, 1'b1);
      check("mr_req", bus.MEM_REQ, 1);
      RST_N = 1'b0;
      tick();
      check("mr_rom_q", bus.ROM_Q, 32'hFFFF);
      check("mr_mem_req", bus.MEM_REQ, 0);
      check("mr_mem_addr", bus.MEM_ADDR, 0);
      check("mr_busy", bus.BUSY, 0);
      check("mr_err", bus.ERR, 0);
      RST_N = 1'b1;
      ack(16'h3333);
      check("mr_late_ack_q", bus.ROM_Q, 32'hFFFF);
      check("mr_late_ack_req", bus.MEM_REQ, 0);

      // Hit buffer disabled: repeated strobes all go to memory
      strobe2(24'h000500, 1'b1);
      check("nc_req1", bus2.MEM_REQ, 1);
      check("nc_addr", bus2.MEM_ADDR, 32'h000280);
      ack2(16'h4444);
      check("nc_q1", bus2.ROM_Q, 32'h4444);
      strobe2(24'h000500, 1'b1);
      check("nc_req2", bus2.MEM_REQ, 1);
      ack2(16'h4545);
      check("nc_q2", bus2.ROM_Q, 32'h4545);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
